// File: rtl/fetch_queue.sv
// Instruction-fetch stage: drives a 1-cycle synchronous instruction memory and buffers
// returned words with their next-PC in a small FIFO that feeds decode over valid/ready.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jmp_cond,
    input  logic [31:0] jmp_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    input  logic        dec_ready,
    output logic [31:0] ir_out,
    output logic [31:0] npc_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0]   DepthW   = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CountOne = CW'(1);
    localparam logic [PW-1:0] PtrOne   = PW'(1);

    logic [31:0]   r_pc;
    logic [31:0]   r_issueAddr;
    logic          r_inflight;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [31:0]   r_irMem  [DEPTH];
    logic [31:0]   r_npcMem [DEPTH];

    logic [CW:0]   w_credit;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;

    // Credit counts the in-flight read so a returning word always has a free slot,
    // even though a same-cycle pop is not taken into account.
    assign w_credit = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue  = !reset && !jmp_cond && (w_credit < DepthW);
    assign w_push   = r_inflight && !jmp_cond;
    assign w_pop    = ir_valid && dec_ready;

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;
    assign ir_valid  = (r_count != '0) && !jmp_cond;
    assign ir_out    = ir_valid ? r_irMem[r_rdPtr]  : 32'h0;
    assign npc_out   = ir_valid ? r_npcMem[r_rdPtr] : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_issueAddr <= RESET_PC;
            r_inflight  <= 1'b0;
            r_count     <= '0;
            r_rdPtr     <= '0;
            r_wrPtr     <= '0;
        end else if (jmp_cond) begin
            // A redirect discards the buffer and the response arriving this cycle.
            r_pc       <= jmp_pc;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc        <= r_pc + PC_STEP;
                r_issueAddr <= r_pc;
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PtrOne;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PtrOne;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CountOne;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CountOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_irMem[r_wrPtr]  <= imem_rdata;
            r_npcMem[r_wrPtr] <= r_issueAddr + PC_STEP;
        end
    end

endmodule
